spi_send: RTL and testbench

SPI_SEND -- requirements
Module: spi_send

---
 rtl/spi_pkg.sv | 22 ++
 rtl/spi_clkgen.sv | 38 +++
 rtl/spi_send.sv | 142 ++++++++++++++
 tb/tb_spi_send.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI frame sender and receiver.
package spi_pkg;

   localparam int SPI_ADDR_W          = 16;
   localparam int FRAME_BYTES_DEFAULT = 8192;

   // Frame-sender states
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      LOAD   = 3'd2,
      SHIFT  = 3'd3,
      LAST   = 3'd4,
      FINISH = 3'd5
   } spi_state_e;

   // Bit that goes on the wire first for a given byte and bit order
   function automatic logic first_bit(input logic [7:0] data, input logic lsb_first);
      return lsb_first ? data[0] : data[7];
   endfunction

endpackage

// File: rtl/spi_clkgen.sv
// Divider for the SPI clock. While enabled it counts CLK_DIV system cycles
// per sclk half-period and emits a one-cycle pulse in the cycle before each
// sclk edge (rise first, then fall). Disabling it clears the count, so every
// enable starts a fresh low half-period.
module spi_clkgen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic rise,
   output logic fall
);

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   logic [7:0] div_cnt;
   logic       phase;
   logic       tick;

   assign tick = en && (div_cnt == DIV_LAST);
   assign rise = tick && !phase;
   assign fall = tick && phase;

   // Divider counter and half-period phase; phase 0 means sclk is low
   always_ff @(posedge clk) begin
      if (rst || !en) begin
         div_cnt <= 8'd0;
         phase   <= 1'b0;
      end else if (tick) begin
         div_cnt <= 8'd0;
         phase   <= ~phase;
      end else begin
         div_cnt <= div_cnt + 8'd1;
      end
   end

endmodule

// File: rtl/spi_send.sv
// Streams FRAME_BYTES bytes from a frame buffer out over a mode-0 SPI link.
// Every output is a register whose value is decided from the next state, so
// mem_rd is high exactly during FETCH and the read data is consumed in LOAD.
module spi_send
   import spi_pkg::*;
#(
   parameter int CLK_DIV     = 4,
   parameter int FRAME_BYTES = FRAME_BYTES_DEFAULT,
   parameter bit LSB_FIRST   = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic [SPI_ADDR_W-1:0] mem_addr,
   output logic                  mem_rd,
   input  logic [7:0]            mem_data,
   output logic                  sclk,
   output logic                  mosi,
   output logic                  cs,
   output spi_state_e            state
);

   // Compare against FRAME_BYTES-1 so a 65536-byte frame ends at 0xFFFF
   localparam logic [SPI_ADDR_W-1:0] LAST_BYTE = SPI_ADDR_W'(FRAME_BYTES - 1);

   spi_state_e            state_n;
   logic [SPI_ADDR_W-1:0] byte_cnt, byte_cnt_n;
   logic [2:0]            bit_cnt, bit_cnt_n;
   logic [7:0]            shreg, shreg_n;
   logic                  sclk_n, mosi_n, cs_n, busy_n, done_n, mem_rd_n;
   logic [SPI_ADDR_W-1:0] mem_addr_n;
   logic                  in_frame;
   logic                  sclk_rise, sclk_fall, div_en;

   assign div_en = (state == SHIFT) || (state == LAST);

   spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
      .clk  (clk),
      .rst  (rst),
      .en   (div_en),
      .rise (sclk_rise),
      .fall (sclk_fall)
   );

   // Next-state and next-output logic
   always_comb begin
      state_n    = state;
      byte_cnt_n = byte_cnt;
      bit_cnt_n  = bit_cnt;
      shreg_n    = shreg;
      sclk_n     = sclk;
      mosi_n     = mosi;
      mem_addr_n = mem_addr;

      case (state)
         IDLE: begin
            if (start) begin
               state_n    = FETCH;
               byte_cnt_n = '0;
            end
         end
         FETCH: state_n = LOAD;
         LOAD: begin
            shreg_n   = mem_data;
            mosi_n    = first_bit(mem_data, LSB_FIRST);
            sclk_n    = 1'b0;
            bit_cnt_n = 3'd0;
            state_n   = SHIFT;
         end
         SHIFT: begin
            if (sclk_rise) begin
               sclk_n = 1'b1;
            end else if (sclk_fall) begin
               sclk_n = 1'b0;
               if (bit_cnt == 3'd7) begin
                  if (byte_cnt == LAST_BYTE) begin
                     state_n = LAST;
                  end else begin
                     byte_cnt_n = byte_cnt + 1'b1;
                     state_n    = FETCH;
                  end
               end else begin
                  // mosi only moves together with the falling sclk edge
                  bit_cnt_n = bit_cnt + 3'd1;
                  shreg_n   = LSB_FIRST ? {1'b0, shreg[7:1]} : {shreg[6:0], 1'b0};
                  mosi_n    = first_bit(shreg_n, LSB_FIRST);
               end
            end
         end
         LAST: begin
            // One low half-period of cs hold time after the final fall
            if (sclk_rise) state_n = FINISH;
         end
         FINISH:  state_n = IDLE;
         default: state_n = IDLE;
      endcase

      in_frame = (state_n == FETCH) || (state_n == LOAD) ||
                 (state_n == SHIFT) || (state_n == LAST);
      busy_n   = in_frame;
      cs_n     = !in_frame;
      done_n   = (state_n == FINISH);
      mem_rd_n = (state_n == FETCH);
      if (state_n == FETCH) mem_addr_n = byte_cnt_n;
      if (!in_frame) begin
         sclk_n = 1'b0;
         mosi_n = 1'b0;
      end
   end

   // State and output registers; reset aborts any frame in progress
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         byte_cnt <= '0;
         bit_cnt  <= 3'd0;
         shreg    <= 8'd0;
         sclk     <= 1'b0;
         mosi     <= 1'b0;
         cs       <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         mem_rd   <= 1'b0;
         mem_addr <= '0;
      end else begin
         state    <= state_n;
         byte_cnt <= byte_cnt_n;
         bit_cnt  <= bit_cnt_n;
         shreg    <= shreg_n;
         sclk     <= sclk_n;
         mosi     <= mosi_n;
         cs       <= cs_n;
         busy     <= busy_n;
         done     <= done_n;
         mem_rd   <= mem_rd_n;
         mem_addr <= mem_addr_n;
      end
   end

endmodule

// File: tb/tb_spi_send.sv
// Bench for spi_send: three instances (CLK_DIV=2/4 bytes LSB-first,
// CLK_DIV=2/4 bytes MSB-first, CLK_DIV=1/1 byte) sharing clock and reset.
module tb_spi_send;
   import spi_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT signals ----------------
   logic        a_start = 1'b0, b_start = 1'b0, c_start = 1'b0;
   logic        a_busy, a_done, a_mem_rd, a_sclk, a_mosi, a_cs;
   logic        b_busy, b_done, b_mem_rd, b_sclk, b_mosi, b_cs;
   logic        c_busy, c_done, c_mem_rd, c_sclk, c_mosi, c_cs;
   logic [15:0] a_mem_addr, b_mem_addr, c_mem_addr;
   logic [7:0]  a_mem_data = 8'd0, b_mem_data = 8'd0, c_mem_data = 8'd0;
   spi_state_e  a_state, b_state, c_state;

   logic [7:0] mem [4] = '{8'h01, 8'h80, 8'hA5, 8'h3C};

   spi_send #(.CLK_DIV(2), .FRAME_BYTES(4), .LSB_FIRST(1'b1)) u_a (
      .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
      .mem_addr(a_mem_addr), .mem_rd(a_mem_rd), .mem_data(a_mem_data),
      .sclk(a_sclk), .mosi(a_mosi), .cs(a_cs), .state(a_state));

   spi_send #(.CLK_DIV(2), .FRAME_BYTES(4), .LSB_FIRST(1'b0)) u_b (
      .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
      .mem_addr(b_mem_addr), .mem_rd(b_mem_rd), .mem_data(b_mem_data),
      .sclk(b_sclk), .mosi(b_mosi), .cs(b_cs), .state(b_state));

   spi_send #(.CLK_DIV(1), .FRAME_BYTES(1), .LSB_FIRST(1'b1)) u_c (
      .clk(clk), .rst(rst), .start(c_start), .busy(c_busy), .done(c_done),
      .mem_addr(c_mem_addr), .mem_rd(c_mem_rd), .mem_data(c_mem_data),
      .sclk(c_sclk), .mosi(c_mosi), .cs(c_cs), .state(c_state));

   // Frame buffers: data valid the cycle after the read strobe
   always @(posedge clk) begin
      if (a_mem_rd) a_mem_data <= mem[a_mem_addr[1:0]];
      if (b_mem_rd) b_mem_data <= mem[b_mem_addr[1:0]];
      if (c_mem_rd) c_mem_data <= mem[c_mem_addr[1:0]];
   end

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   logic [7:0]  exp_q[$];
   logic [15:0] addr_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor A: slave model + timing ----------------
   int         a_rises = 0, a_dones = 0, a_nbits = 0;
   int         a_high_len = 0, a_low_len = 0, a_tail = 0;
   bit         a_in_tail = 0;
   logic [7:0] a_shift = 8'd0;
   logic       a_prev_sclk = 1'b0, a_prev_mosi = 1'b0, a_prev_cs = 1'b1;
   logic [15:0] a_prev_addr = 16'd0;

   always @(negedge clk) begin : mon_a
      logic [7:0]  e;
      logic [15:0] ea;
      // cs hold after the final fall
      if (a_in_tail) begin
         if (a_cs) begin
            check("cs_hold_after_last_fall", 32'(a_tail), 2);
            a_in_tail = 0;
         end else begin
            a_tail++;
         end
      end
      if (a_cs && !a_prev_cs) a_nbits = 0;
      if (a_cs) check("mosi_low_when_cs_high", 32'(a_mosi), 0);
      if (a_sclk) check("mosi_stable_sclk_high", 32'(a_mosi), 32'(a_prev_mosi));
      if (a_sclk && !a_prev_sclk) begin
         a_rises++;
         check("cs_low_at_rise", 32'(a_cs), 0);
         if (a_rises > 1)
            check("sclk_low_len", 32'(a_low_len), (a_nbits == 0) ? 4 : 2);
         a_shift = {a_mosi, a_shift[7:1]};
         a_nbits++;
         if (a_nbits == 8) begin
            a_nbits = 0;
            if (exp_q.size() == 0) begin
               check("byte_unexpected", 32'(a_shift), 32'hFFFF);
            end else begin
               e = exp_q.pop_front();
               check("byte_lsb_first", 32'(a_shift), 32'(e));
            end
         end
         a_high_len = 1;
      end else if (a_sclk) begin
         a_high_len++;
      end
      if (!a_sclk && a_prev_sclk) begin
         check("sclk_high_len", 32'(a_high_len), 2);
         a_low_len = 1;
         if (a_rises == 32) begin
            a_in_tail = 1;
            a_tail = 1;
         end
      end else if (!a_sclk) begin
         a_low_len++;
      end
      if (a_done) begin
         a_dones++;
         check("busy_low_at_done", 32'(a_busy), 0);
      end
      if (a_mem_rd) begin
         if (addr_q.size() == 0) begin
            check("addr_unexpected", 32'(a_mem_addr), 32'hFFFF);
         end else begin
            ea = addr_q.pop_front();
            check("mem_addr_seq", 32'(a_mem_addr), 32'(ea));
         end
      end
      if (!a_cs && !a_mem_rd) check("mem_addr_hold", 32'(a_mem_addr), 32'(a_prev_addr));
      a_prev_sclk = a_sclk;
      a_prev_mosi = a_mosi;
      a_prev_cs   = a_cs;
      a_prev_addr = a_mem_addr;
   end

   // ---------------- monitors B and C ----------------
   int   b_nbits = 0;
   logic b_bits [8];
   logic b_prev_sclk = 1'b0;
   int   c_rises = 0;
   logic [7:0] c_byte = 8'd0;
   logic c_prev_sclk = 1'b0;

   always @(negedge clk) begin
      if (b_sclk && !b_prev_sclk) begin
         if (b_nbits < 8) b_bits[b_nbits] = b_mosi;
         b_nbits++;
      end
      b_prev_sclk = b_sclk;
      if (c_sclk && !c_prev_sclk) begin
         c_rises++;
         c_byte = {c_mosi, c_byte[7:1]};
      end
      c_prev_sclk = c_sclk;
   end

   // ---------------- driver tasks ----------------
   task automatic run_a(input bit spam, input int abort_at);
      bit finished = 0;
      a_rises = 0;
      a_dones = 0;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(mem[i]);
         addr_q.push_back(16'(i));
      end
      @(posedge clk); #1 a_start = 1'b1;
      @(posedge clk); #1 if (!spam) a_start = 1'b0;
      for (int n = 0; n < 2000 && !finished; n++) begin
         if (a_dones > 0) begin
            finished = 1;
         end else if (abort_at > 0 && a_rises >= abort_at) begin
            rst = 1'b1;
            a_start = 1'b0;
            @(posedge clk); #1;
            check("abort_cs", 32'(a_cs), 1);
            check("abort_sclk", 32'(a_sclk), 0);
            check("abort_busy", 32'(a_busy), 0);
            rst = 1'b0;
            exp_q.delete();
            addr_q.delete();
            finished = 1;
         end else begin
            @(posedge clk); #1;
         end
      end
      a_start = 1'b0;
      if (!finished) check("a_frame_timeout", 0, 1);
      repeat (10) @(posedge clk);
      #1;
   endtask

   typedef struct {
      bit spam;
      int abort_at;
      int exp_rises;
      int exp_dones;
   } row_t;

   row_t rows [4];
   logic exp_b_bits [8];
   int   start_cyc, done_cyc;
   bit   got;

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rows[0] = '{spam: 0, abort_at: 0,  exp_rises: 32, exp_dones: 1};
      rows[1] = '{spam: 1, abort_at: 0,  exp_rises: 32, exp_dones: 1};
      rows[2] = '{spam: 0, abort_at: 13, exp_rises: 13, exp_dones: 0};
      rows[3] = '{spam: 0, abort_at: 0,  exp_rises: 32, exp_dones: 1};
      exp_b_bits = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

      // Reset state
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_state", 32'(a_state), 32'(IDLE));
      check("rst_cs", 32'(a_cs), 1);
      check("rst_sclk", 32'(a_sclk), 0);
      check("rst_mosi", 32'(a_mosi), 0);
      check("rst_busy", 32'(a_busy), 0);
      check("rst_done", 32'(a_done), 0);
      check("rst_mem_rd", 32'(a_mem_rd), 0);
      check("rst_mem_addr", 32'(a_mem_addr), 0);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Frame scenarios on instance A
      for (int i = 0; i < 4; i++) begin
         run_a(rows[i].spam, rows[i].abort_at);
         check($sformatf("row%0d_rises", i), 32'(a_rises), 32'(rows[i].exp_rises));
         check($sformatf("row%0d_dones", i), 32'(a_dones), 32'(rows[i].exp_dones));
         if (rows[i].abort_at == 0) begin
            check($sformatf("row%0d_bytes_left", i), 32'(exp_q.size()), 0);
            check($sformatf("row%0d_addrs_left", i), 32'(addr_q.size()), 0);
         end
      end

      // MSB-first bit order on instance B
      b_nbits = 0;
      @(posedge clk); #1 b_start = 1'b1;
      @(posedge clk); #1 b_start = 1'b0;
      got = 0;
      for (int n = 0; n < 2000 && !got; n++) begin
         @(negedge clk);
         if (b_done) got = 1;
      end
      if (!got) check("b_frame_timeout", 0, 1);
      for (int i = 0; i < 8; i++)
         check($sformatf("msb_first_bit%0d", i), 32'(b_bits[i]), 32'(exp_b_bits[i]));
      check("b_total_rises", 32'(b_nbits), 32);

      // Single byte at CLK_DIV=1 on instance C: latency and flow
      c_rises = 0;
      @(posedge clk); #1 c_start = 1'b1;
      start_cyc = cyc;
      @(posedge clk); #1 c_start = 1'b0;
      check("c_busy_after_accept", 32'(c_busy), 1);
      check("c_cs_after_accept", 32'(c_cs), 0);
      check("c_fetch_rd", 32'(c_mem_rd), 1);
      check("c_fetch_addr", 32'(c_mem_addr), 0);
      check("c_state_fetch", 32'(c_state), 32'(FETCH));
      got = 0;
      done_cyc = 0;
      for (int n = 0; n < 200 && !got; n++) begin
         @(negedge clk);
         if (c_done) begin
            got = 1;
            done_cyc = cyc;
         end
      end
      if (!got) check("c_frame_timeout", 0, 1);
      check("c_done_latency", 32'(done_cyc - start_cyc), 20);
      check("c_rises", 32'(c_rises), 8);
      check("c_byte", 32'(c_byte), 32'h01);
      @(negedge clk);
      check("c_done_one_cycle", 32'(c_done), 0);
      check("c_cs_idle", 32'(c_cs), 1);

      check("exp_q_empty", 32'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
